// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: MDU state encoding, register-zero constant
// and the default multiply/divide latency.
package pipe_pkg;

  localparam int unsigned MDU_CNT_W       = 6;
  localparam int unsigned MDU_LAT_DEFAULT = 32;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Pipeline steering bundle produced by the hazard priority logic
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bus: decode/execute status in, pipeline stall/flush controls out.
interface hazard_ctrl_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       id_jump;
  logic       ex_mdu_start;
  logic       id_mdu_read;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mdu_busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, id_jump, ex_mdu_start, id_mdu_read,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, mdu_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, id_jump, ex_mdu_start, id_mdu_read,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, mdu_busy
  );

endinterface

// File: rtl/hazard_ctrl_mdu_timer.sv
// Multiply/divide busy sequencer: counts MDU_LAT cycles after each issue,
// restarting on a new issue; only reset can abort a count.
module mdu_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LAT - 1);

  mdu_state_e           state, state_nxt;
  logic [MDU_CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      MDU_IDLE: begin
        if (start) begin
          state_nxt = MDU_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      MDU_BUSY: begin
        if (start) begin
          cnt_nxt = CNT_LOAD;
        end else if (cnt == '0) begin
          state_nxt = MDU_IDLE;
        end else begin
          cnt_nxt = cnt - MDU_CNT_W'(1);
        end
      end
      default: begin
        state_nxt = MDU_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use and MDU-read stalls, branch/jump flushes.
// The MDU sequencer is built only when HAZARD_CTRL_MDU_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  logic     load_use_c;
  logic     mdu_stall_c;
  logic     mdu_busy_q;
  hz_ctrl_t ctrl_c;

`ifdef HAZARD_CTRL_MDU_EN
  mdu_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clock (clock),
    .reset (reset),
    .start (bus.ex_mdu_start),
    .busy  (mdu_busy_q)
  );

  assign mdu_stall_c = mdu_busy_q & bus.id_mdu_read;
`else
  logic unused_mdu_in;

  assign mdu_busy_q    = 1'b0;
  assign mdu_stall_c   = 1'b0;
  assign unused_mdu_in = ^{bus.ex_mdu_start, bus.id_mdu_read, MDU_CNT_W'(MDU_LAT)};
`endif

  // A load into r0 never creates a dependency
  assign load_use_c = bus.ex_mem_read && (bus.ex_rt != REG_ZERO) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));

  // Priority: reset > branch redirect > stall > jump flush
  always_comb begin
    ctrl_c = '0;
    if (reset) begin
      ctrl_c = '0;
    end else if (bus.ex_branch_taken) begin
      ctrl_c.if_id_flush = 1'b1;
      ctrl_c.id_ex_flush = 1'b1;
    end else if (load_use_c || mdu_stall_c) begin
      ctrl_c.pc_stall    = 1'b1;
      ctrl_c.if_id_stall = 1'b1;
      ctrl_c.id_ex_flush = 1'b1;
    end else if (bus.id_jump) begin
      ctrl_c.if_id_flush = 1'b1;
    end
  end

  assign bus.pc_stall    = ctrl_c.pc_stall;
  assign bus.if_id_stall = ctrl_c.if_id_stall;
  assign bus.if_id_flush = ctrl_c.if_id_flush;
  assign bus.id_ex_flush = ctrl_c.id_ex_flush;
  assign bus.mdu_busy    = mdu_busy_q;

endmodule
